// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: opcodes, FSM states and the
// width of the error counter.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int ERR_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin picker. It owns the last_grant register and returns a
// one-hot winner; last_grant moves only when advance is strobed with a winner.
module rr_arb2 (
    input  logic       mclk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       advance,
    output logic [1:0] win
);

    logic last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win = 2'b00;
        if (req0 && (!req1 || last_grant)) begin
            win = 2'b01;
        end else if (req1) begin
            win = 2'b10;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (win != 2'b00)) begin
            last_grant <= win[1];
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two requesters onto the shared combinational ALU, registers the
// operands, captures the tagged result and counts error results.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [1:0]           op0,
    input  logic [1:0]           op1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    output logic [1:0]           alu_op,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_error,
    output logic [2*WIDTH-1:0]   res,
    output logic                 res_zero,
    output logic                 res_error,
    output logic                 res_id,
    output logic                 res_valid,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t     state;
    state_t     next_state;
    logic [1:0] win;
    logic       owner;
    logic       sample;

    assign sample = (state == IDLE);
    assign busy   = (state == EXEC);

    rr_arb2 u_arb (
        .mclk    (mclk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .advance (sample),
        .win     (win)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win != 2'b00) next_state = EXEC;
            EXEC:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant edge latches the winner's operands; the following edge captures
    // whatever the ALU settled to during the EXEC cycle.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_op    <= '0;
            owner     <= 1'b0;
            res       <= '0;
            res_zero  <= 1'b0;
            res_error <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            err_cnt   <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            res_valid <= 1'b0;
            if (state == IDLE) begin
                if (win != 2'b00) begin
                    gnt0    <= win[0];
                    gnt1    <= win[1];
                    owner   <= win[1];
                    alu_op  <= win[1] ? op1 : op0;
                    alu_in1 <= win[1] ? a1 : a0;
                    alu_in2 <= win[1] ? b1 : b0;
                end
            end else begin
                res       <= alu_result;
                res_zero  <= alu_zero;
                res_error <= alu_error;
                res_id    <= owner;
                res_valid <= 1'b1;
                if (alu_error && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural ALU attached to its
// alu_* outputs; vector table plus hand sequences for multi-cycle cases.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 3;

    logic             mclk = 1'b0;
    logic             rst  = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [1:0]       op0 = '0, op1 = '0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] alu_in1, alu_in2;
    logic [1:0]       alu_op;
    logic [2*WIDTH-1:0] alu_result;
    logic             alu_zero, alu_error;
    logic [2*WIDTH-1:0] res;
    logic             res_zero, res_error, res_id, res_valid, busy;
    logic [3:0]       err_cnt;

    int compared   = 0;
    int mismatched = 0;

    always #5 mclk = ~mclk;

    alu_req_arbiter #(.WIDTH(WIDTH)) dut (
        .mclk(mclk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_error(alu_error),
        .res(res), .res_zero(res_zero), .res_error(res_error),
        .res_id(res_id), .res_valid(res_valid), .busy(busy), .err_cnt(err_cnt)
    );

    // Behavioural ALU: 6-bit wrapping add/sub/mul, divide by zero flags error.
    always_comb begin
        alu_result = '0;
        alu_error  = 1'b0;
        case (alu_op)
            OP_ADD: alu_result = {3'b000, alu_in1} + {3'b000, alu_in2};
            OP_SUB: alu_result = {3'b000, alu_in1} - {3'b000, alu_in2};
            OP_MUL: alu_result = {3'b000, alu_in1} * {3'b000, alu_in2};
            default: begin
                if (alu_in2 == '0) alu_error = 1'b1;
                else alu_result = {3'b000, alu_in1 / alu_in2};
            end
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic       r0, r1;
        logic [1:0] o0;
        logic [2:0] x0, y0;
        logic [1:0] o1;
        logic [2:0] x1, y1;
        logic       g0, g1;
        logic [5:0] eres;
        logic       eid, ezero, eerr;
        logic [3:0] ecnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        req0 = v.r0; op0 = v.o0; a0 = v.x0; b0 = v.y0;
        req1 = v.r1; op1 = v.o1; a1 = v.x1; b1 = v.y1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " gnt0"}, gnt0, 0);
        check_output({tag, " gnt1"}, gnt1, 0);
        check_output({tag, " alu_in1"}, alu_in1, 0);
        check_output({tag, " alu_in2"}, alu_in2, 0);
        check_output({tag, " alu_op"}, alu_op, 0);
        check_output({tag, " res"}, res, 0);
        check_output({tag, " res_flags"}, {res_zero, res_error, res_id}, 0);
        check_output({tag, " res_valid"}, res_valid, 0);
        check_output({tag, " busy"}, busy, 0);
        check_output({tag, " err_cnt"}, err_cnt, 0);
    endtask

    task automatic check_grant(input string tag, input logic g0, input logic g1);
        check_output({tag, " gnt0"}, gnt0, g0);
        check_output({tag, " gnt1"}, gnt1, g1);
        check_output({tag, " busy"}, busy, 1);
        check_output({tag, " res_valid_low"}, res_valid, 0);
    endtask

    task automatic check_result(input string tag, input logic [5:0] r, input logic id);
        check_output({tag, " res_valid"}, res_valid, 1);
        check_output({tag, " res"}, res, r);
        check_output({tag, " res_id"}, res_id, id);
        check_output({tag, " gnt_low"}, {gnt0, gnt1}, 0);
        check_output({tag, " busy_low"}, busy, 0);
    endtask

    initial begin
        // Expected values hand-computed; last_grant starts at 1 after reset.
        //            r0 r1  o0     a0 b0  o1     a1 b1  g0 g1 res id z  e  cnt
        vecs[0]  = '{1, 1, OP_SUB, 5, 2, OP_MUL, 2, 2, 1, 0,  3, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, OP_SUB, 5, 2, OP_MUL, 2, 2, 0, 1,  4, 1, 0, 0, 0};
        vecs[2]  = '{1, 1, OP_SUB, 5, 2, OP_MUL, 2, 2, 1, 0,  3, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, OP_ADD, 3, 1, OP_ADD, 0, 0, 1, 0,  4, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, OP_ADD, 0, 0, OP_DIV, 4, 0, 0, 1,  0, 1, 1, 1, 1};
        vecs[5]  = '{0, 1, OP_ADD, 0, 0, OP_DIV, 4, 2, 0, 1,  2, 1, 0, 0, 1};
        vecs[6]  = '{1, 0, OP_SUB, 2, 2, OP_ADD, 0, 0, 1, 0,  0, 0, 1, 0, 1};
        vecs[7]  = '{1, 0, OP_MUL, 3, 3, OP_ADD, 0, 0, 1, 0,  9, 0, 0, 0, 1};
        vecs[8]  = '{0, 1, OP_ADD, 0, 0, OP_SUB, 1, 3, 0, 1, 62, 1, 0, 0, 1};
        vecs[9]  = '{1, 1, OP_ADD, 7, 7, OP_ADD, 1, 1, 1, 0, 14, 0, 0, 0, 1};
        vecs[10] = '{1, 1, OP_ADD, 7, 7, OP_ADD, 1, 1, 0, 1,  2, 1, 0, 0, 1};

        #1;
        check_all_zero("reset");
        repeat (2) @(posedge mclk);
        #1 rst = 1'b0;
        check_all_zero("post_reset");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            @(posedge mclk); #1;
            check_grant($sformatf("v%0d", i), vecs[i].g0, vecs[i].g1);
            check_output($sformatf("v%0d alu_in1", i), alu_in1, vecs[i].g1 ? vecs[i].x1 : vecs[i].x0);
            check_output($sformatf("v%0d alu_in2", i), alu_in2, vecs[i].g1 ? vecs[i].y1 : vecs[i].y0);
            check_output($sformatf("v%0d alu_op", i), alu_op, vecs[i].g1 ? vecs[i].o1 : vecs[i].o0);
            req0 = 1'b0; req1 = 1'b0;
            @(posedge mclk); #1;
            check_result($sformatf("v%0d", i), vecs[i].eres, vecs[i].eid);
            check_output($sformatf("v%0d res_zero", i), res_zero, vecs[i].ezero);
            check_output($sformatf("v%0d res_error", i), res_error, vecs[i].eerr);
            check_output($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].ecnt);
        end

        // Both held continuously: alternating grants, back to back with results.
        op0 = OP_ADD; a0 = 1; b0 = 2;
        op1 = OP_SUB; a1 = 6; b1 = 1;
        req0 = 1'b1; req1 = 1'b1;
        @(posedge mclk); #1 check_grant("hold e1", 1, 0);
        @(posedge mclk); #1 check_result("hold e2", 3, 0);
        @(posedge mclk); #1 check_grant("hold e3", 0, 1);
        @(posedge mclk); #1 check_result("hold e4", 5, 1);
        @(posedge mclk); #1 check_grant("hold e5", 1, 0);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge mclk); #1 check_result("hold e6", 3, 0);
        @(posedge mclk); #1;
        check_output("hold e7 res_valid", res_valid, 0);
        check_output("hold e7 gnt", {gnt0, gnt1}, 0);

        // Reset while EXEC: outputs clear at once, the operation is dropped.
        op1 = OP_DIV; a1 = 4; b1 = 0; req1 = 1'b1;
        @(posedge mclk); #1 check_grant("rst_exec", 0, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_async");
        req1 = 1'b0;
        @(posedge mclk); #1;
        check_output("rst_hold res_valid", res_valid, 0);
        rst = 1'b0;
        @(posedge mclk); #1;
        check_output("rst_after res_valid", res_valid, 0);
        check_output("rst_after err_cnt", err_cnt, 0);
        op0 = OP_ADD; a0 = 1; b0 = 1; op1 = OP_ADD; a1 = 2; b1 = 2;
        req0 = 1'b1; req1 = 1'b1;
        @(posedge mclk); #1 check_grant("rst_tie", 1, 0);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge mclk); #1 check_result("rst_tie", 2, 0);

        // Seventeen divide-by-zero results: counter saturates at 15.
        op0 = OP_DIV; a0 = 5; b0 = 0;
        for (int i = 0; i < 17; i++) begin
            req0 = 1'b1;
            @(posedge mclk); #1 check_grant($sformatf("sat%0d", i), 1, 0);
            req0 = 1'b0;
            @(posedge mclk); #1;
            check_output($sformatf("sat%0d res_valid", i), res_valid, 1);
            check_output($sformatf("sat%0d res_error", i), res_error, 1);
            check_output($sformatf("sat%0d err_cnt", i), err_cnt, (i + 1 > 15) ? 15 : i + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
